// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory port between two requesters:
//   port 0 = WASM loader, port 1 = CPU fetch/execute unit.
// One transaction is granted at a time. The grant is held until the memory
// completes the transaction or the optional watchdog expires. The winner then
// receives a one-cycle ready pulse together with its read data.
//
// Parameters
//   ADDR_W     address width on all ports
//   DATA_W     data width on all ports
//   FIXED_PRIO 0 = round-robin, 1 = port 0 always wins a tie
//   TIMEOUT    GRANT cycles to wait for memory_ready before aborting, 0 = no watchdog
//   TIMEOUT_W  watchdog counter width
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   pN_addr / pN_data_in         requester address / write data
//   pN_read_en / pN_write_en     level requests, held until pN_ready
//   pN_data_out                  read data, valid with pN_ready, held afterwards
//   pN_ready / pN_err            completion pulse / timed-out qualifier
//   addr, data_in                memory address / write data
//   data_out                     memory read data
//   memory_read_en/write_en      memory request
//   memory_ready                 memory completion
//   grant                        current or last owner
//   busy                         high in GRANT and RELEASE

module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 8,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data_in,
    input  logic              p0_read_en,
    input  logic              p0_write_en,
    output logic [DATA_W-1:0] p0_data_out,
    output logic              p0_ready,
    output logic              p0_err,

    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data_in,
    input  logic              p1_read_en,
    input  logic              p1_write_en,
    output logic [DATA_W-1:0] p1_data_out,
    output logic              p1_ready,
    output logic              p1_err,

    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              memory_read_en,
    output logic              memory_write_en,
    input  logic              memory_ready,

    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    // Last watchdog count before the abort fires; unused when TIMEOUT is 0.
    localparam logic [TIMEOUT_W-1:0] WdLast = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e               state;
    logic                 last_grant;
    logic [TIMEOUT_W-1:0] wd_cnt;

    logic              req0;
    logic              req1;
    logic              any_req;
    logic              winner;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_write;
    logic              win_read;
    logic              wd_expired;

    // Winner selection from the live requests; only consumed in IDLE.
    always_comb begin
        req0    = p0_read_en | p0_write_en;
        req1    = p1_read_en | p1_write_en;
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else begin
            winner = req1;
        end
        win_addr  = winner ? p1_addr     : p0_addr;
        win_data  = winner ? p1_data_in  : p0_data_in;
        win_write = winner ? p1_write_en : p0_write_en;
        // A write takes precedence over a simultaneous read.
        win_read  = (winner ? p1_read_en : p0_read_en) & ~win_write;
    end

    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WdLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            last_grant      <= 1'b1;
            grant           <= 1'b0;
            busy            <= 1'b0;
            wd_cnt          <= '0;
            addr            <= '0;
            data_in         <= '0;
            memory_read_en  <= 1'b0;
            memory_write_en <= 1'b0;
            p0_data_out     <= '0;
            p1_data_out     <= '0;
            p0_ready        <= 1'b0;
            p1_ready        <= 1'b0;
            p0_err          <= 1'b0;
            p1_err          <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        addr            <= win_addr;
                        data_in         <= win_data;
                        memory_write_en <= win_write;
                        memory_read_en  <= win_read;
                        grant           <= winner;
                        last_grant      <= winner;
                        wd_cnt          <= '0;
                        busy            <= 1'b1;
                        state           <= StGrant;
                    end
                end

                StGrant: begin
                    // memory_ready wins over a watchdog expiry in the same cycle.
                    if (memory_ready) begin
                        memory_read_en  <= 1'b0;
                        memory_write_en <= 1'b0;
                        if (grant) begin
                            p1_data_out <= memory_read_en ? data_out : '0;
                            p1_ready    <= 1'b1;
                            p1_err      <= 1'b0;
                        end else begin
                            p0_data_out <= memory_read_en ? data_out : '0;
                            p0_ready    <= 1'b1;
                            p0_err      <= 1'b0;
                        end
                        state <= StRelease;
                    end else if (wd_expired) begin
                        memory_read_en  <= 1'b0;
                        memory_write_en <= 1'b0;
                        if (grant) begin
                            p1_data_out <= '0;
                            p1_ready    <= 1'b1;
                            p1_err      <= 1'b1;
                        end else begin
                            p0_data_out <= '0;
                            p0_ready    <= 1'b1;
                            p0_err      <= 1'b1;
                        end
                        state <= StRelease;
                    end else if (wd_cnt != '1) begin
                        // Saturate rather than wrap.
                        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
                    end
                end

                StRelease: begin
                    // Ready/err pulse lasts exactly this one cycle; no arbitration here.
                    p0_ready <= 1'b0;
                    p1_ready <= 1'b0;
                    p0_err   <= 1'b0;
                    p1_err   <= 1'b0;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// dut_a: round-robin, TIMEOUT=4. dut_b: fixed priority, no watchdog.
// Each DUT has a small memory model. The model answers a configurable number
// of cycles after the enable rises, and its read data is addr[7:0] ^ 8'h38.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 8;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_rd, p0_wr, p1_rd, p1_wr;

    logic [DW-1:0] a_p0_dout, a_p1_dout, a_din, a_rdata;
    logic          a_p0_ready, a_p1_ready, a_p0_err, a_p1_err;
    logic [AW-1:0] a_addr;
    logic          a_mrd, a_mwr, a_mready, a_grant, a_busy;

    logic [DW-1:0] b_p0_dout, b_p1_dout, b_din, b_rdata;
    logic          b_p0_ready, b_p1_ready, b_p0_err, b_p1_err;
    logic [AW-1:0] b_addr;
    logic          b_mrd, b_mwr, b_mready, b_grant, b_busy;

    int   mem_lat = 2;
    logic a_spur  = 1'b0;
    int   a_cnt, b_cnt;

    int tests = 0;
    int fails = 0;

    int a_rd_cyc = 0, a_err_cyc = 0, a_p0_rdy = 0, a_p1_rdy = 0;
    int b_p0_rdy = 0, b_p1_rdy = 0;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0), .TIMEOUT(4), .TIMEOUT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_data_in(p0_wdata), .p0_read_en(p0_rd), .p0_write_en(p0_wr),
        .p0_data_out(a_p0_dout), .p0_ready(a_p0_ready), .p0_err(a_p0_err),
        .p1_addr(p1_addr), .p1_data_in(p1_wdata), .p1_read_en(p1_rd), .p1_write_en(p1_wr),
        .p1_data_out(a_p1_dout), .p1_ready(a_p1_ready), .p1_err(a_p1_err),
        .addr(a_addr), .data_in(a_din), .data_out(a_rdata),
        .memory_read_en(a_mrd), .memory_write_en(a_mwr), .memory_ready(a_mready),
        .grant(a_grant), .busy(a_busy)
    );

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1), .TIMEOUT(0), .TIMEOUT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_data_in(p0_wdata), .p0_read_en(p0_rd), .p0_write_en(p0_wr),
        .p0_data_out(b_p0_dout), .p0_ready(b_p0_ready), .p0_err(b_p0_err),
        .p1_addr(p1_addr), .p1_data_in(p1_wdata), .p1_read_en(p1_rd), .p1_write_en(p1_wr),
        .p1_data_out(b_p1_dout), .p1_ready(b_p1_ready), .p1_err(b_p1_err),
        .addr(b_addr), .data_in(b_din), .data_out(b_rdata),
        .memory_read_en(b_mrd), .memory_write_en(b_mwr), .memory_ready(b_mready),
        .grant(b_grant), .busy(b_busy)
    );

    // Memory models: count cycles the enable has been high.
    always @(posedge clk or posedge rst) begin
        if (rst) a_cnt <= 0;
        else if (a_mrd | a_mwr) a_cnt <= a_cnt + 1;
        else a_cnt <= 0;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) b_cnt <= 0;
        else if (b_mrd | b_mwr) b_cnt <= b_cnt + 1;
        else b_cnt <= 0;
    end
    assign a_mready = a_spur | ((a_mrd | a_mwr) && mem_lat != 0 && a_cnt == mem_lat - 1);
    assign a_rdata  = a_addr[7:0] ^ 8'h38;
    assign b_mready = (b_mrd | b_mwr) && b_cnt == 1;
    assign b_rdata  = b_addr[7:0] ^ 8'h38;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(input logic port, input logic [DW-1:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drop_all();
        p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
    endtask

    // Wait (bounded) for a ready pulse on dut_a, then release the requests.
    task automatic wait_done(input int bound, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            n++;
            seen = a_p0_ready | a_p1_ready;
        end
        check("ready_seen", seen, 1);
        drop_all();
    endtask

    // Scoreboard and event counters, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic port;
        a_rd_cyc  <= a_rd_cyc + int'(a_mrd);
        a_err_cyc <= a_err_cyc + int'(a_p0_err | a_p1_err);
        a_p0_rdy  <= a_p0_rdy + int'(a_p0_ready);
        a_p1_rdy  <= a_p1_rdy + int'(a_p1_ready);
        b_p0_rdy  <= b_p0_rdy + int'(b_p0_ready);
        b_p1_rdy  <= b_p1_rdy + int'(b_p1_ready);
        if (a_p0_ready || a_p1_ready) begin
            check("one_ready", a_p0_ready & a_p1_ready, 0);
            check("ready_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e    = exp_q.pop_front();
                port = a_p1_ready;
                check("sb_port", port, e.port);
                check("sb_data", port ? a_p1_dout : a_p0_dout, e.data);
                check("sb_err", port ? a_p1_err : a_p0_err, e.err);
            end
        end
    end

    initial begin
        int n;
        int s_rd, s_err, s_p0, s_p1, s_b0, s_b1;

        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        drop_all();
        settle(2);

        // Reset state
        check("rst_mrd", a_mrd, 0);
        check("rst_mwr", a_mwr, 0);
        check("rst_p0_ready", a_p0_ready, 0);
        check("rst_p1_ready", a_p1_ready, 0);
        check("rst_p0_err", a_p0_err, 0);
        check("rst_p0_dout", a_p0_dout, 0);
        check("rst_p1_dout", a_p1_dout, 0);
        check("rst_addr", a_addr, 0);
        check("rst_grant", a_grant, 0);
        check("rst_busy", a_busy, 0);
        rst = 1'b0;
        settle(1);

        // Single read, memory answers in the second enable cycle
        mem_lat = 2;
        s_rd = a_rd_cyc; s_p0 = a_p0_rdy; s_p1 = a_p1_rdy;
        p0_addr = 32'h30; p0_rd = 1'b1;
        expect_txn(1'b0, 8'h08, 1'b0);
        wait_done(10, n);
        check("rd_latency", n, 3);
        settle(2);
        check("rd_en_cycles", a_rd_cyc - s_rd, 2);
        check("rd_p0_pulses", a_p0_rdy - s_p0, 1);
        check("rd_p1_pulses", a_p1_rdy - s_p1, 0);
        check("rd_hold", a_p0_dout, 8'h08);
        check("rd_busy_after", a_busy, 0);

        // p1 read with combinational memory: minimum latency
        mem_lat = 1;
        p1_addr = 32'h41; p1_rd = 1'b1;
        expect_txn(1'b1, 8'h79, 1'b0);
        wait_done(10, n);
        check("min_latency", n, 2);
        settle(2);
        check("loser_untouched", a_p0_dout, 8'h08);

        // Write with read_en also high
        mem_lat = 2;
        p1_addr = 32'h100; p1_wdata = 8'hA5; p1_rd = 1'b1; p1_wr = 1'b1;
        expect_txn(1'b1, 8'h00, 1'b0);
        settle(1);
        check("wr_mwr", a_mwr, 1);
        check("wr_mrd", a_mrd, 0);
        check("wr_din", a_din, 8'hA5);
        check("wr_addr", a_addr, 32'h100);
        check("wr_grant", a_grant, 1);
        check("wr_busy", a_busy, 1);
        wait_done(10, n);
        settle(2);
        check("wr_p0_hold", a_p0_dout, 8'h08);

        // Watchdog: memory never answers
        mem_lat = 0;
        s_rd = a_rd_cyc; s_err = a_err_cyc;
        p0_addr = 32'h30; p0_rd = 1'b1;
        expect_txn(1'b0, 8'h00, 1'b1);
        wait_done(20, n);
        check("to_latency", n, 5);
        settle(2);
        check("to_en_cycles", a_rd_cyc - s_rd, 4);
        check("to_err_cycles", a_err_cyc - s_err, 1);

        // memory_ready in the same cycle the watchdog would fire
        mem_lat = 4;
        s_rd = a_rd_cyc; s_err = a_err_cyc;
        p0_rd = 1'b1;
        expect_txn(1'b0, 8'h08, 1'b0);
        wait_done(20, n);
        check("race_latency", n, 5);
        settle(2);
        check("race_en_cycles", a_rd_cyc - s_rd, 4);
        check("race_err_cycles", a_err_cyc - s_err, 0);

        // Spurious memory_ready while idle
        s_p0 = a_p0_rdy; s_p1 = a_p1_rdy;
        a_spur = 1'b1;
        settle(4);
        a_spur = 1'b0;
        settle(1);
        check("spur_ready", (a_p0_rdy - s_p0) + (a_p1_rdy - s_p1), 0);
        check("spur_busy", a_busy, 0);

        // Reset one cycle into a read
        mem_lat = 3;
        s_p0 = a_p0_rdy;
        p0_addr = 32'h30; p0_rd = 1'b1;
        settle(1);
        check("mid_pre_mrd", a_mrd, 1);
        rst = 1'b1;
        #1;
        check("mid_mrd", a_mrd, 0);
        check("mid_busy", a_busy, 0);
        settle(1);
        rst = 1'b0;
        drop_all();
        settle(4);
        check("mid_no_ready", a_p0_rdy - s_p0, 0);

        // First tie after reset goes to port 0
        mem_lat = 2;
        p0_addr = 32'h30; p0_rd = 1'b1;
        p1_addr = 32'h41; p1_rd = 1'b1;
        expect_txn(1'b0, 8'h08, 1'b0);
        wait_done(10, n);
        settle(2);

        // Continuous contention from reset: round-robin (a) vs fixed priority (b)
        rst = 1'b1;
        settle(1);
        rst = 1'b0;
        settle(1);
        s_p0 = a_p0_rdy; s_p1 = a_p1_rdy; s_b0 = b_p0_rdy; s_b1 = b_p1_rdy;
        expect_txn(1'b0, 8'h08, 1'b0);
        expect_txn(1'b1, 8'h79, 1'b0);
        expect_txn(1'b0, 8'h08, 1'b0);
        expect_txn(1'b1, 8'h79, 1'b0);
        p0_addr = 32'h30; p0_rd = 1'b1;
        p1_addr = 32'h41; p1_rd = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        drop_all();
        settle(3);
        check("rr_drained", exp_q.size(), 0);
        check("rr_p0_count", a_p0_rdy - s_p0, 2);
        check("rr_p1_count", a_p1_rdy - s_p1, 2);
        check("fp_p0_count", b_p0_rdy - s_b0, 4);
        check("fp_p1_count", b_p1_rdy - s_b1, 0);
        check("fp_p0_dout", b_p0_dout, 8'h08);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
